direction_scan_ctrl: RTL and testbench
======================================

Name: direction_scan_ctrl

Overview:
- Sequences the frame-buffer read sweep that feeds the red-pixel direction datapath, one full scan per captured camera frame.
- Generates BRAM read addresses and pixel-aligned strobes (valid, first, last, column).
- Captures the datapath's heading once the pipeline drains, and presents it to the motor/servo stage over a valid/ready handshake.
- Sits between the camera-capture BRAM write side (frame_done) and the detection datapath/actuator logic.

Parameters:
- IMAGE_WIDTH, 320: pixels per row
- IMAGE_HEIGHT, 240: rows per frame
- ADDR_BITS, $clog2(IMAGE_WIDTH*IMAGE_HEIGHT): BRAM address width
- RD_LATENCY, 1: BRAM read latency in cycles (1..3)
- DRAIN_CYCLES, 4: cycles after last pixel before the datapath result is stable (>=1)
- DIR_BITS, 7: heading width

Ports:
- clk, in, 1: 50 MHz system clock
- reset, in, 1: synchronous, active-high reset
- frame_done, in, 1: one-cycle pulse; a new frame is complete in BRAM
- rdaddress, out, ADDR_BITS: BRAM read address
- rden, out, 1: BRAM read enable
- pix_valid, out, 1: rddata this cycle belongs to the scan
- pix_first, out, 1: with pix_valid, pixel 0 of the frame
- pix_last, out, 1: with pix_valid, final pixel of the frame
- pix_column, out, $clog2(IMAGE_WIDTH): column of the current valid pixel
- dir_in, in, DIR_BITS: heading from the detection datapath
- dir_out, out, DIR_BITS: captured heading
- dir_valid, out, 1: dir_out is valid
- dir_ready, in, 1: consumer accepts dir_out
- busy, out, 1: state != IDLE
- overrun_count, out, 8: saturating count of dropped frame_done pulses

Behaviour:
- Reset:
  - state = IDLE; rdaddress = 0; rden = 0; all pix_* = 0.
  - dir_out = 0; dir_valid = 0; overrun_count = 0; pending = 0.
  - Reset asserted mid-scan aborts the scan immediately; no result is produced.
- States: IDLE, SCAN, DRAIN, REPORT.
- IDLE:
  - On frame_done or pending: go to SCAN, clear pending, set rdaddress = 0, rden = 1.
- SCAN:
  - rden = 1; rdaddress increments by 1 per cycle.
  - A row counter and a column counter run in step with rdaddress; no divide/modulo is used.
  - Column wraps at IMAGE_WIDTH-1, row increments on the wrap.
  - When rdaddress == IMAGE_WIDTH*IMAGE_HEIGHT-1, the next state is DRAIN and rden deasserts.
- Pixel strobes:
  - pix_valid, pix_first, pix_last and pix_column are the address-side values delayed by exactly RD_LATENCY cycles through a shift register.
  - pix_valid is high for exactly IMAGE_WIDTH*IMAGE_HEIGHT cycles per scan.
- DRAIN:
  - Counts DRAIN_CYCLES cycles, starting after pix_last has been emitted.
  - On the final count, captures dir_out <= dir_in, sets dir_valid = 1, and goes to REPORT.
- REPORT:
  - dir_valid is held with dir_out stable until dir_valid && dir_ready; then dir_valid falls the next cycle.
  - Leaves for IDLE, or for SCAN directly if pending is set.
- frame_done while busy:
  - Sets pending if clear.
  - If pending is already set, overrun_count increments, saturating at 255.
  - frame_done in the same cycle REPORT completes is treated as pending; no overrun.
- Latency, from frame_done to first pix_valid: 1 + RD_LATENCY cycles.

Optional Feature:
- Macro SCAN_ROW_DECIMATE_EN.
- Defined:
  - SCAN reads only even rows. rdaddress jumps by IMAGE_WIDTH+1 at each row end.
  - pix_last marks the final pixel of the last even row.
  - pix_valid count = IMAGE_WIDTH*ceil(IMAGE_HEIGHT/2).
- Undefined: every row is scanned as above.

Decomposition:
- Package direction_pkg holds:
  - scan_state_t enum {IDLE, SCAN, DRAIN, REPORT}
  - FRAME_PIXELS localparam
  - the shared image-size defaults
- One sub-module, scan_strobe_delay: parameterised RD_LATENCY shift register carrying the {valid, first, last, column} bundle.

Test Plan:
- Single frame, IMAGE_WIDTH=8, IMAGE_HEIGHT=4, RD_LATENCY=1:
  - frame_done at cycle 10 -> rdaddress 0..31 on cycles 11..42; pix_valid on cycles 12..43.
  - pix_first at cycle 12, pix_last at cycle 43; pix_column sequence 0..7 repeating.
- Result handshake:
  - Drive dir_in = 7'd12 and hold dir_ready = 0 for 20 cycles -> dir_valid rises DRAIN_CYCLES cycles after pix_last.
  - dir_out = 12 held stable; dir_valid falls one cycle after dir_ready = 1.
- Overrun: three frame_done pulses during one scan -> pending = 1, overrun_count = 2; second scan starts right after the REPORT handshake.
- Reset mid-scan at rdaddress = 17 -> next cycle: state IDLE, rden = 0, dir_valid = 0, overrun_count = 0; no pix_valid follows.
- Saturation: 300 extra frame_done pulses while busy -> overrun_count = 255.
- SCAN_ROW_DECIMATE_EN defined, 8x4 frame -> rdaddress visits 0..7, then 16..23; pix_valid count = 16; pix_last on address 23.

Source files
------------

// File: rtl/direction_pkg.sv
// Shared types and defaults for the direction scan controller.
// Contents: scan FSM state type, default image geometry, frame size and a
// width helper that never returns zero.
package direction_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    REPORT
  } scan_state_t;

  localparam int unsigned DEF_IMAGE_WIDTH  = 320;
  localparam int unsigned DEF_IMAGE_HEIGHT = 240;
  localparam int unsigned FRAME_PIXELS     = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;

  // Counter width for values 0..v-1, kept at least one bit wide.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/scan_strobe_delay.sv
// Delays the address-side pixel strobe bundle {valid, first, last, column}
// by Latency cycles so it lines up with BRAM read data.
// Ports:
//   clk_i, reset_i      - clock, synchronous active-high reset
//   valid_i .. col_i    - strobes aligned with the read address
//   valid_o .. col_o    - the same strobes aligned with the read data
module scan_strobe_delay #(
  parameter int unsigned Latency = 1,
  parameter int unsigned ColBits = 9
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic               first_i,
  input  logic               last_i,
  input  logic [ColBits-1:0] col_i,
  output logic               valid_o,
  output logic               first_o,
  output logic               last_o,
  output logic [ColBits-1:0] col_o
);

  localparam int unsigned Width = ColBits + 3;

  logic [Width-1:0] stage_d [Latency];
  logic [Width-1:0] stage_q [Latency];

  always_comb begin
    stage_d[0] = {valid_i, first_i, last_i, col_i};
    for (int unsigned i = 1; i < Latency; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign {valid_o, first_o, last_o, col_o} = stage_q[Latency-1];

endmodule

// File: rtl/direction_scan_ctrl.sv
// Frame-buffer read sweep controller for the red-pixel direction datapath.
// One full scan per frame_done: issues BRAM reads, emits data-aligned pixel
// strobes, waits for the datapath to settle, then offers the heading to the
// actuator stage over valid/ready. A frame_done arriving while busy is held
// as pending; further ones are counted as overruns (saturating).
// Optional build macro SCAN_ROW_DECIMATE_EN: scan only even rows.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   frame_done            - new frame available in BRAM (one-cycle pulse)
//   rdaddress, rden       - BRAM read port
//   pix_valid/first/last  - strobes aligned with BRAM read data
//   pix_column            - column of the current valid pixel
//   dir_in                - heading from the detection datapath
//   dir_out, dir_valid,
//   dir_ready             - captured heading handshake
//   busy                  - controller not idle
//   overrun_count         - saturating count of dropped frame_done pulses
module direction_scan_ctrl
  import direction_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int unsigned IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int unsigned ADDR_BITS    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned DIR_BITS     = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_done,
  output logic [ADDR_BITS-1:0]           rdaddress,
  output logic                           rden,
  output logic                           pix_valid,
  output logic                           pix_first,
  output logic                           pix_last,
  output logic [$clog2(IMAGE_WIDTH)-1:0] pix_column,
  input  logic [DIR_BITS-1:0]            dir_in,
  output logic [DIR_BITS-1:0]            dir_out,
  output logic                           dir_valid,
  input  logic                           dir_ready,
  output logic                           busy,
  output logic [7:0]                     overrun_count
);

  localparam int unsigned ColBits = $clog2(IMAGE_WIDTH);
  localparam int unsigned RowBits = clog2_min1(IMAGE_HEIGHT);
`ifdef SCAN_ROW_DECIMATE_EN
  localparam int unsigned RowStep = 2;
`else
  localparam int unsigned RowStep = 1;
`endif
  // Skipping a row means jumping past the rest of this row plus one full row.
  localparam int unsigned AddrJump = (RowStep == 2) ? IMAGE_WIDTH + 1 : 1;
  localparam int unsigned LastRow  = ((IMAGE_HEIGHT - 1) / RowStep) * RowStep;
  // DRAIN starts the cycle after the last read; pix_last appears RD_LATENCY
  // cycles after that read, and the result is due DRAIN_CYCLES after pix_last.
  localparam int unsigned DrainTotal = RD_LATENCY + DRAIN_CYCLES - 1;
  localparam int unsigned DrainBits  = clog2_min1(DrainTotal);

  localparam logic [ColBits-1:0]   ColMax    = ColBits'(IMAGE_WIDTH - 1);
  localparam logic [RowBits-1:0]   RowLast   = RowBits'(LastRow);
  localparam logic [RowBits-1:0]   RowInc    = RowBits'(RowStep);
  localparam logic [ADDR_BITS-1:0] AddrInc   = ADDR_BITS'(AddrJump);
  localparam logic [DrainBits-1:0] DrainLast = DrainBits'(DrainTotal - 1);

  scan_state_t          state_d, state_q;
  logic [ADDR_BITS-1:0] rdaddress_d, rdaddress_q;
  logic                 rden_d, rden_q;
  logic [ColBits-1:0]   col_d, col_q;
  logic [RowBits-1:0]   row_d, row_q;
  logic [DrainBits-1:0] drain_cnt_d, drain_cnt_q;
  logic                 pending_d, pending_q;
  logic [7:0]           overrun_d, overrun_q;
  logic [DIR_BITS-1:0]  dir_out_d, dir_out_q;
  logic                 dir_valid_d, dir_valid_q;

  logic last_hit;
  logic report_done;

  assign last_hit    = (row_q == RowLast) && (col_q == ColMax);
  assign report_done = (state_q == REPORT) && dir_valid_q && dir_ready;

  always_comb begin
    state_d     = state_q;
    rdaddress_d = rdaddress_q;
    rden_d      = rden_q;
    col_d       = col_q;
    row_d       = row_q;
    drain_cnt_d = drain_cnt_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    dir_out_d   = dir_out_q;
    dir_valid_d = dir_valid_q;

    // The REPORT completion cycle handles frame_done itself below.
    if (frame_done && (state_q != IDLE) && !report_done) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (overrun_q != 8'hFF) begin
        overrun_d = overrun_q + 8'd1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (frame_done || pending_q) begin
          state_d     = SCAN;
          rdaddress_d = '0;
          rden_d      = 1'b1;
          col_d       = '0;
          row_d       = '0;
          // Both at once: serve one, keep the other queued.
          pending_d   = frame_done && pending_q;
        end
      end
      SCAN: begin
        if (last_hit) begin
          state_d     = DRAIN;
          rden_d      = 1'b0;
          drain_cnt_d = '0;
        end else if (col_q == ColMax) begin
          col_d       = '0;
          row_d       = row_q + RowInc;
          rdaddress_d = rdaddress_q + AddrInc;
        end else begin
          col_d       = col_q + 1'b1;
          rdaddress_d = rdaddress_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DrainLast) begin
          dir_out_d   = dir_in;
          dir_valid_d = 1'b1;
          state_d     = REPORT;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      REPORT: begin
        if (report_done) begin
          dir_valid_d = 1'b0;
          if (pending_q) begin
            state_d     = SCAN;
            rdaddress_d = '0;
            rden_d      = 1'b1;
            col_d       = '0;
            row_d       = '0;
            pending_d   = frame_done;
          end else begin
            state_d   = IDLE;
            pending_d = frame_done;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rdaddress_q <= '0;
      rden_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      drain_cnt_q <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= '0;
      dir_out_q   <= '0;
      dir_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdaddress_q <= rdaddress_d;
      rden_q      <= rden_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drain_cnt_q <= drain_cnt_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      dir_out_q   <= dir_out_d;
      dir_valid_q <= dir_valid_d;
    end
  end

  logic               addr_first;
  logic               addr_last;
  logic [ColBits-1:0] addr_col;

  assign addr_first = rden_q && (rdaddress_q == '0);
  assign addr_last  = rden_q && last_hit;
  assign addr_col   = rden_q ? col_q : '0;

  scan_strobe_delay #(
    .Latency (RD_LATENCY),
    .ColBits (ColBits)
  ) u_strobe_delay (
    .clk_i   (clk),
    .reset_i (reset),
    .valid_i (rden_q),
    .first_i (addr_first),
    .last_i  (addr_last),
    .col_i   (addr_col),
    .valid_o (pix_valid),
    .first_o (pix_first),
    .last_o  (pix_last),
    .col_o   (pix_column)
  );

  assign rdaddress     = rdaddress_q;
  assign rden          = rden_q;
  assign dir_out       = dir_out_q;
  assign dir_valid     = dir_valid_q;
  assign busy          = (state_q != IDLE);
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_direction_scan_ctrl.sv
// Self-checking bench for direction_scan_ctrl on an 8x4 frame.
module tb_direction_scan_ctrl;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int RDL = 1;
  localparam int DRN = 4;
  localparam int DB  = 7;
  localparam int AB  = $clog2(W * H);
  localparam int CB  = $clog2(W);
`ifdef SCAN_ROW_DECIMATE_EN
  localparam int RSTEP = 2;
`else
  localparam int RSTEP = 1;
`endif
  localparam int NPIX = W * ((H + RSTEP - 1) / RSTEP);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_done = 1'b0;
  logic [AB-1:0] rdaddress;
  logic          rden;
  logic          pix_valid, pix_first, pix_last;
  logic [CB-1:0] pix_column;
  logic [DB-1:0] dir_in = '0;
  logic [DB-1:0] dir_out;
  logic          dir_valid;
  logic          dir_ready = 1'b0;
  logic          busy;
  logic [7:0]    overrun_count;

  int errors = 0;
  int checks = 0;
  int addrs[$];

  direction_scan_ctrl #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .ADDR_BITS    (AB),
    .RD_LATENCY   (RDL),
    .DRAIN_CYCLES (DRN),
    .DIR_BITS     (DB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_done    (frame_done),
    .rdaddress     (rdaddress),
    .rden          (rden),
    .pix_valid     (pix_valid),
    .pix_first     (pix_first),
    .pix_last      (pix_last),
    .pix_column    (pix_column),
    .dir_in        (dir_in),
    .dir_out       (dir_out),
    .dir_valid     (dir_valid),
    .dir_ready     (dir_ready),
    .busy          (busy),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    frame_done = 1'b0;
    dir_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Reference scan order: visited rows, each read left to right.
  function automatic void build_addrs();
    addrs.delete();
    for (int r = 0; r < H; r += RSTEP)
      for (int c = 0; c < W; c++) addrs.push_back(r * W + c);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    frame_done = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, rden, rdaddress} !== '0) begin
      errors++;
      $display("FAIL reset_addr_side: got busy=%b rden=%b addr=%0d, expected 0 0 0",
               busy, rden, rdaddress);
    end
    checks++;
    if ({pix_valid, pix_first, pix_last, pix_column} !== '0) begin
      errors++;
      $display("FAIL reset_pix: got v=%b f=%b l=%b col=%0d, expected all 0",
               pix_valid, pix_first, pix_last, pix_column);
    end
    checks++;
    if ({dir_valid, dir_out, overrun_count} !== '0) begin
      errors++;
      $display("FAIL reset_result: got dv=%b dir=%0d ov=%0d, expected all 0",
               dir_valid, dir_out, overrun_count);
    end
    frame_done = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_pending: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single_frame();
    int k;
    bit exp_rden, exp_pv, exp_dv;
    apply_reset();
    dir_in = DB'(12);
    repeat (5) tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    for (int j = 1; j <= NPIX + RDL + DRN + 20; j++) begin
      exp_rden = (j <= NPIX);
      checks++;
      if (rden !== exp_rden) begin
        errors++;
        $display("FAIL rden j=%0d: got %b expected %b", j, rden, exp_rden);
      end
      if (exp_rden) begin
        checks++;
        if (rdaddress !== AB'(addrs[j-1])) begin
          errors++;
          $display("FAIL rdaddress j=%0d: got %0d expected %0d", j, rdaddress, addrs[j-1]);
        end
      end
      k = j - 1 - RDL;
      exp_pv = (k >= 0) && (k < NPIX);
      checks++;
      if ({pix_valid, pix_first, pix_last} !==
          {exp_pv, exp_pv && (k == 0), exp_pv && (k == NPIX - 1)}) begin
        errors++;
        $display("FAIL strobes j=%0d: got v=%b f=%b l=%b expected v=%b f=%b l=%b", j,
                 pix_valid, pix_first, pix_last, exp_pv, exp_pv && (k == 0),
                 exp_pv && (k == NPIX - 1));
      end
      if (exp_pv) begin
        checks++;
        if (pix_column !== CB'(addrs[k] % W)) begin
          errors++;
          $display("FAIL pix_column j=%0d: got %0d expected %0d", j, pix_column, addrs[k] % W);
        end
      end
      exp_dv = (j >= RDL + NPIX + DRN);
      checks++;
      if ({busy, dir_valid} !== {1'b1, exp_dv}) begin
        errors++;
        $display("FAIL busy_dir_valid j=%0d: got busy=%b dv=%b expected 1 %b", j, busy,
                 dir_valid, exp_dv);
      end
      if (exp_dv) begin
        checks++;
        if (dir_out !== DB'(12)) begin
          errors++;
          $display("FAIL dir_out_hold j=%0d: got %0d expected 12", j, dir_out);
        end
      end
      if (j == RDL + NPIX + DRN) dir_in = DB'(99);
      tick();
    end
    dir_ready = 1'b1;
    tick();
    dir_ready = 1'b0;
    checks++;
    if ({dir_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL handshake_release: got dv=%b busy=%b expected 0 0", dir_valid, busy);
    end
  endtask

  task automatic test_overrun();
    int c, npv;
    apply_reset();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    c = 0;
    while (dir_valid !== 1'b1 && c < 300) begin
      frame_done = (c == 3) || (c == 8) || (c == 13);
      tick();
      c++;
    end
    frame_done = 1'b0;
    checks++;
    if (overrun_count !== 8'd2 || dir_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_count: got ov=%0d dv=%b expected 2 1", overrun_count, dir_valid);
    end
    repeat (3) tick();
    dir_ready = 1'b1;
    tick();
    dir_ready = 1'b0;
    checks++;
    if ({busy, rden, dir_valid, rdaddress} !== {1'b1, 1'b1, 1'b0, AB'(0)}) begin
      errors++;
      $display("FAIL pending_restart: got busy=%b rden=%b dv=%b addr=%0d expected 1 1 0 0",
               busy, rden, dir_valid, rdaddress);
    end
    c = 0;
    npv = 0;
    while (dir_valid !== 1'b1 && c < 300) begin
      if (pix_valid === 1'b1) npv++;
      tick();
      c++;
    end
    checks++;
    if (npv !== NPIX || overrun_count !== 8'd2) begin
      errors++;
      $display("FAIL second_scan: got pixels=%0d ov=%0d expected %0d 2", npv,
               overrun_count, NPIX);
    end
    dir_ready = 1'b1;
    tick();
    dir_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_second: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    int c, bad;
    apply_reset();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    c = 0;
    while (!(rden === 1'b1 && rdaddress === AB'(17)) && c < 100) begin
      frame_done = (c == 2) || (c == 4);
      tick();
      c++;
    end
    frame_done = 1'b0;
    checks++;
    if (overrun_count !== 8'd1 || rdaddress !== AB'(17)) begin
      errors++;
      $display("FAIL pre_reset_state: got ov=%0d addr=%0d expected 1 17", overrun_count,
               rdaddress);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, rden, dir_valid, overrun_count, rdaddress} !== '0) begin
      errors++;
      $display("FAIL mid_scan_reset: got busy=%b rden=%b dv=%b ov=%0d addr=%0d expected 0",
               busy, rden, dir_valid, overrun_count, rdaddress);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (pix_valid !== 1'b0 || busy !== 1'b0 || dir_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL post_reset_quiet: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_saturation();
    int exp_ov;
    apply_reset();
    frame_done = 1'b1;
    tick();
    for (int k = 1; k <= 301; k++) begin
      tick();
      exp_ov = (k - 1 > 255) ? 255 : k - 1;
      if (k == 100 || k == 256 || k == 257 || k == 301) begin
        checks++;
        if (overrun_count !== 8'(exp_ov)) begin
          errors++;
          $display("FAIL saturation k=%0d: got %0d expected %0d", k, overrun_count, exp_ov);
        end
      end
    end
    frame_done = 1'b0;
    dir_ready = 1'b1;
    tick();
    dir_ready = 1'b0;
    checks++;
    if ({busy, rdaddress, overrun_count} !== {1'b1, AB'(0), 8'd255}) begin
      errors++;
      $display("FAIL saturation_restart: got busy=%b addr=%0d ov=%0d expected 1 0 255",
               busy, rdaddress, overrun_count);
    end
  endtask

  task automatic test_random();
    int ov_exp, p, base, c, npv, dv, wait_n;
    apply_reset();
    ov_exp = 0;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    for (int it = 0; it < 8; it++) begin
      dv = $urandom_range(0, 127);
      dir_in = DB'(dv);
      p = $urandom_range(0, 3);
      base = $urandom_range(1, 4);
      c = 0;
      npv = 0;
      while (dir_valid !== 1'b1 && c < 300) begin
        if (pix_valid === 1'b1) npv++;
        frame_done = (c >= base) && ((c - base) % 5 == 0) && ((c - base) / 5 < p);
        tick();
        c++;
      end
      frame_done = 1'b0;
      checks++;
      if (dir_valid !== 1'b1 || npv !== NPIX || dir_out !== DB'(dv)) begin
        errors++;
        $display("FAIL rand_scan it=%0d: got dv=%b pixels=%0d dir=%0d expected 1 %0d %0d",
                 it, dir_valid, npv, dir_out, NPIX, dv);
      end
      wait_n = $urandom_range(0, 4);
      dir_in = DB'($urandom_range(0, 127));
      repeat (wait_n) tick();
      checks++;
      if (dir_valid !== 1'b1 || dir_out !== DB'(dv)) begin
        errors++;
        $display("FAIL rand_hold it=%0d: got dv=%b dir=%0d expected 1 %0d", it, dir_valid,
                 dir_out, dv);
      end
      dir_ready = 1'b1;
      tick();
      dir_ready = 1'b0;
      if (p > 1) ov_exp += p - 1;
      if (ov_exp > 255) ov_exp = 255;
      checks++;
      if ({dir_valid, busy, overrun_count} !== {1'b0, p > 0, 8'(ov_exp)}) begin
        errors++;
        $display("FAIL rand_after it=%0d: got dv=%b busy=%b ov=%0d expected 0 %b %0d", it,
                 dir_valid, busy, overrun_count, p > 0, ov_exp);
      end
      if (p == 0) begin
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
      end
    end
  endtask

  initial begin
    build_addrs();
    test_reset();
    test_single_frame();
    test_overrun();
    test_reset_mid_scan();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
